// File: rtl/norm_shift_gen.sv
// rtl/norm_shift_gen.sv - sequential leading-one detector producing the FP add/sub normalization shift (optional NORM_ZERO_FAST_EN)
module norm_shift_gen #(
    parameter int SWR   = 26,
    parameter int EWR   = 5,
    parameter int CHUNK = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [SWR-1:0] Data_i,
    input  logic           ack_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [EWR-1:0] Shift_Value_o,
    output logic           Left_Right_o,
    output logic           zero_o
);

    localparam int NCH = (SWR - 1 + CHUNK - 1) / CHUNK;
    localparam int WW  = NCH * CHUNK;
    localparam int PAD = WW - (SWR - 1);
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [WW-1:0]  win_q, win_d;
    logic [KW-1:0]  k_q, k_d;
    logic [EWR-1:0] sv_q, sv_d;
    logic           lr_q, lr_d;
    logic           z_q, z_d;

    logic [WW-1:0]    win_load;
    logic [CHUNK-1:0] chunk;
    logic             hit;
    logic             k_last;
    logic             accept;
    logic [EWR-1:0]   lz;
    logic [EWR-1:0]   scan_sv;

    // Scan window is left-justified and zero-padded so that the examined
    // chunk is always the top CHUNK bits; the window shifts left on a miss.
    assign win_load = WW'(Data_i[SWR-2:0]) << PAD;
    assign chunk    = win_q[WW-1 -: CHUNK];
    assign hit      = |chunk;
    assign k_last   = (k_q == KW'(NCH - 1));
    assign accept   = start_i && ((state_q == IDLE) || ((state_q == DONE) && ack_i));

    always_comb begin
        lz = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (chunk[i]) begin
                lz = EWR'(CHUNK - 1 - i);
            end
        end
    end

    assign scan_sv = EWR'(k_q) * EWR'(CHUNK) + lz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            win_q   <= '0;
            k_q     <= '0;
            sv_q    <= '0;
            lr_q    <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            k_q     <= k_d;
            sv_q    <= sv_d;
            lr_q    <= lr_d;
            z_q     <= z_d;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        k_d     = k_q;
        sv_d    = sv_q;
        lr_d    = lr_q;
        z_d     = z_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    win_d = win_load;
                    k_d   = '0;
                    if (Data_i[SWR-1]) begin
                        // Carry out of the add: one right shift renormalizes.
                        state_d = DONE;
                        sv_d    = EWR'(1);
                        lr_d    = 1'b0;
                        z_d     = 1'b0;
`ifdef NORM_ZERO_FAST_EN
                    end else if (Data_i == '0) begin
                        state_d = DONE;
                        sv_d    = '0;
                        lr_d    = 1'b1;
                        z_d     = 1'b1;
`endif
                    end else begin
                        state_d = SCAN;
                    end
                end else if ((state_q == DONE) && ack_i) begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (hit) begin
                    state_d = DONE;
                    sv_d    = scan_sv;
                    lr_d    = 1'b1;
                    z_d     = 1'b0;
                end else if (k_last) begin
                    state_d = DONE;
                    sv_d    = '0;
                    lr_d    = 1'b1;
                    z_d     = 1'b1;
                end else begin
                    k_d   = k_q + KW'(1);
                    win_d = win_q << CHUNK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o        = (state_q == SCAN);
    assign done_o        = (state_q == DONE);
    assign Shift_Value_o = sv_q;
    assign Left_Right_o  = lr_q;
    assign zero_o        = z_q;

endmodule

// File: tb/tb_norm_shift_gen.sv
// tb/tb_norm_shift_gen.sv - directed table-driven bench for norm_shift_gen
module tb_norm_shift_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [25:0] Data_i = '0;
    logic        ack_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic [4:0]  Shift_Value_o;
    logic        Left_Right_o;
    logic        zero_o;

    int n_checks = 0;
    int n_errors = 0;

`ifdef NORM_ZERO_FAST_EN
    localparam int ZERO_BUSY = 0;
`else
    localparam int ZERO_BUSY = 7;
`endif

    norm_shift_gen dut (
        .clk          (clk),
        .rst          (rst_n),
        .start_i      (start_i),
        .Data_i       (Data_i),
        .ack_i        (ack_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .Shift_Value_o(Shift_Value_o),
        .Left_Right_o (Left_Right_o),
        .zero_o       (zero_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [25:0] data;
        int          busy;
        logic [4:0]  sv;
        logic        lr;
        logic        z;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Returns at the negedge after the capture edge, with start_i released.
    task automatic start_op(input logic [25:0] d);
        @(negedge clk);
        start_i = 1'b1;
        Data_i  = d;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(output int busy_cnt);
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (done_o) return;
            if (busy_o) busy_cnt++;
            @(negedge clk);
        end
        check("done_timeout", 0, 1);
    endtask

    task automatic do_ack;
        ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
    endtask

    initial begin
        int  bc;
        vecs[0] = '{26'h2000000, 0,         5'd1,  1'b0, 1'b0};
        vecs[1] = '{26'h1000000, 1,         5'd0,  1'b1, 1'b0};
        vecs[2] = '{26'h0000200, 4,         5'd15, 1'b1, 1'b0};
        vecs[3] = '{26'h0000001, 7,         5'd24, 1'b1, 1'b0};
        vecs[4] = '{26'h0000000, ZERO_BUSY, 5'd0,  1'b1, 1'b1};
        vecs[5] = '{26'h0800000, 1,         5'd1,  1'b1, 1'b0};
        vecs[6] = '{26'h3FFFFFF, 0,         5'd1,  1'b0, 1'b0};
        vecs[7] = '{26'h0000010, 6,         5'd20, 1'b1, 1'b0};
        vecs[8] = '{26'h0100000, 2,         5'd4,  1'b1, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_sv", Shift_Value_o, 0);
        check("rst_lr", Left_Right_o, 0);
        check("rst_zero", zero_o, 0);
        rst_n = 1'b1;

        for (int v = 0; v < 9; v++) begin
            start_op(vecs[v].data);
            wait_done(bc);
            check($sformatf("v%0d_busy_cycles", v), bc, vecs[v].busy);
            check($sformatf("v%0d_done", v), done_o, 1);
            check($sformatf("v%0d_sv", v), Shift_Value_o, vecs[v].sv);
            check($sformatf("v%0d_lr", v), Left_Right_o, vecs[v].lr);
            check($sformatf("v%0d_zero", v), zero_o, vecs[v].z);
            do_ack();
            check($sformatf("v%0d_done_drop", v), done_o, 0);
            check($sformatf("v%0d_sv_hold", v), Shift_Value_o, vecs[v].sv);
        end

        // Result held in DONE while ack_i is low.
        start_op(26'h0000200);
        wait_done(bc);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_done", done_o, 1);
            check("hold_sv", Shift_Value_o, 15);
        end

        // ack + start together in DONE: straight back into SCAN.
        ack_i   = 1'b1;
        start_i = 1'b1;
        Data_i  = 26'h0800000;
        @(negedge clk);
        ack_i   = 1'b0;
        start_i = 1'b0;
        check("bb_busy", busy_o, 1);
        check("bb_done", done_o, 0);
        wait_done(bc);
        check("bb_sv", Shift_Value_o, 1);
        check("bb_lr", Left_Right_o, 1);

        // start without ack in DONE is ignored.
        start_i = 1'b1;
        Data_i  = 26'h2000000;
        @(negedge clk);
        start_i = 1'b0;
        check("done_nostart_sv", Shift_Value_o, 1);
        check("done_nostart_lr", Left_Right_o, 1);
        do_ack();

        // start during SCAN is ignored.
        start_op(26'h0000001);
        @(negedge clk);
        start_i = 1'b1;
        Data_i  = 26'h2000000;
        @(negedge clk);
        start_i = 1'b0;
        wait_done(bc);
        check("midscan_sv", Shift_Value_o, 24);
        check("midscan_lr", Left_Right_o, 1);
        do_ack();

        // Asynchronous reset in SCAN aborts with no done.
        start_op(26'h0000001);
        @(negedge clk);
        check("pre_rst_busy", busy_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy_o, 0);
        check("arst_done", done_o, 0);
        check("arst_sv", Shift_Value_o, 0);
        check("arst_lr", Left_Right_o, 0);
        check("arst_zero", zero_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bc = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done_o || busy_o) bc++;
        end
        check("post_rst_quiet", bc, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
